// File: rtl/cpu_memory_writeback.sv
`default_nettype none
// ============================================================================
// Module      : cpu_memory_writeback
// Description : Writeback stage that forwards ALU results or runs one data-bus
//               read for loads, then commits to the register file write port.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_memory_writeback #(
  parameter int TAG_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic [4:0]           i_rd_idx,
  input  logic [31:0]          i_result,
  input  logic                 i_is_load,
  input  logic [2:0]           i_funct3,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic                 o_busy,
  output logic                 o_bus_request,
  output logic [31:0]          o_bus_address,
  input  logic                 i_bus_ready,
  input  logic [31:0]          i_bus_rdata,
  output logic [TAG_WIDTH-1:0] o_write_tag,
  output logic [4:0]           o_write_rd_idx,
  output logic [31:0]          o_rd,
  output logic                 o_fault
);

  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_BUS   = 2'd1;
  localparam logic [1:0] c_ST_WRITE = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [TAG_WIDTH-1:0] r_write_tag;
  logic [4:0]           r_write_rd_idx;
  logic [31:0]          r_rd;
  logic                 r_fault;
  logic                 r_bus_request;
  logic [31:0]          r_bus_address;
  logic [c_CNT_W-1:0]   r_count;
  logic [TAG_WIDTH-1:0] r_cap_tag;
  logic [4:0]           r_cap_idx;
  logic [2:0]           r_cap_funct3;
  logic [1:0]           r_cap_addr_lo;
  logic [31:0]          r_load_data;

  logic                 w_new_req;
  logic                 w_illegal;
  logic                 w_misaligned;
  logic                 w_load_ok;
  logic                 w_alu_commit;
  logic                 w_load_reject;
  logic                 w_load_start;
  logic                 w_bus_done;
  logic                 w_timeout;
  logic                 w_write_commit;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_ext;

  assign w_new_req    = (i_tag != r_tag);
  assign w_illegal    = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11);
  assign w_misaligned = ((i_funct3[1:0] == 2'b01) && i_result[0]) ||
                        ((i_funct3 == 3'b010) && (i_result[1:0] != 2'b00));
  assign w_load_ok    = i_is_load && !w_illegal && !w_misaligned;

  // State register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_new_req && w_load_ok) w_state_next = c_ST_BUS;
      end
      c_ST_BUS: begin
        if (i_bus_ready)                 w_state_next = c_ST_WRITE;
        else if (r_count == c_CNT_LAST)  w_state_next = c_ST_IDLE;
      end
      c_ST_WRITE: w_state_next = c_ST_IDLE;
      default:    w_state_next = c_ST_IDLE;
    endcase
  end

  // Output / action decode
  always_comb begin
    o_busy         = (r_state != c_ST_IDLE);
    w_alu_commit   = (r_state == c_ST_IDLE) && w_new_req && !i_is_load;
    w_load_reject  = (r_state == c_ST_IDLE) && w_new_req && i_is_load && !w_load_ok;
    w_load_start   = (r_state == c_ST_IDLE) && w_new_req && w_load_ok;
    w_bus_done     = (r_state == c_ST_BUS) && i_bus_ready;
    w_timeout      = (r_state == c_ST_BUS) && !i_bus_ready && (r_count == c_CNT_LAST);
    w_write_commit = (r_state == c_ST_WRITE);
  end

  // Byte/half lane selection from the captured low address bits
  always_comb begin
    w_byte = i_bus_rdata[7:0];
    case (r_cap_addr_lo)
      2'd0: w_byte = i_bus_rdata[7:0];
      2'd1: w_byte = i_bus_rdata[15:8];
      2'd2: w_byte = i_bus_rdata[23:16];
      2'd3: w_byte = i_bus_rdata[31:24];
      default: w_byte = i_bus_rdata[7:0];
    endcase
    w_half = r_cap_addr_lo[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    w_ext  = i_bus_rdata;
    case (r_cap_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = i_bus_rdata;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_tag          <= '0;
      r_write_tag    <= '0;
      r_write_rd_idx <= '0;
      r_rd           <= '0;
      r_fault        <= 1'b0;
      r_bus_request  <= 1'b0;
      r_bus_address  <= '0;
      r_count        <= '0;
      r_cap_tag      <= '0;
      r_cap_idx      <= '0;
      r_cap_funct3   <= '0;
      r_cap_addr_lo  <= '0;
      r_load_data    <= '0;
    end else begin
      if (w_alu_commit) begin
        r_tag <= i_tag;
        if (i_rd_idx != 5'd0) begin
          r_rd           <= i_result;
          r_write_rd_idx <= i_rd_idx;
          r_write_tag    <= r_write_tag + TAG_WIDTH'(1);
        end
      end else if (w_load_reject) begin
        r_fault <= 1'b1;
        r_tag   <= i_tag;
      end else if (w_load_start) begin
        r_cap_tag     <= i_tag;
        r_cap_idx     <= i_rd_idx;
        r_cap_funct3  <= i_funct3;
        r_cap_addr_lo <= i_result[1:0];
        r_bus_request <= 1'b1;
        r_bus_address <= {i_result[31:2], 2'b00};
        r_count       <= '0;
      end else if (w_bus_done) begin
        r_bus_request <= 1'b0;
        r_load_data   <= w_ext;
      end else if (w_timeout) begin
        r_bus_request <= 1'b0;
        r_fault       <= 1'b1;
        r_tag         <= r_cap_tag;
        r_count       <= '0;
      end else if (r_state == c_ST_BUS) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (w_write_commit) begin
        r_tag <= r_cap_tag;
        if (r_cap_idx != 5'd0) begin
          r_rd           <= r_load_data;
          r_write_rd_idx <= r_cap_idx;
          r_write_tag    <= r_write_tag + TAG_WIDTH'(1);
        end
      end
    end
  end

  assign o_tag          = r_tag;
  assign o_write_tag    = r_write_tag;
  assign o_write_rd_idx = r_write_rd_idx;
  assign o_rd           = r_rd;
  assign o_fault        = r_fault;
  assign o_bus_request  = r_bus_request;
  assign o_bus_address  = r_bus_address;

endmodule
`default_nettype wire
